// File: rtl/axi_read_burst_tracker.sv
// axi_read_burst_tracker: splits a beat-count read request into aligned AR bursts,
// bounds bursts in flight, and pulses done once every requested beat has returned.
module axi_read_burst_tracker #(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_DATA_WIDTH      = 512,
    parameter int C_XFER_WIDTH      = 32,
    parameter int C_BURST_LEN       = 64,
    parameter int C_MAX_OUTSTANDING = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0]                    ctrl_addr_offset,
    input  logic [C_XFER_WIDTH-1:0]                    ctrl_xfer_beats,
    output logic                                       ctrl_busy,
    output logic                                       ctrl_done,
    output logic                                       m_arvalid,
    input  logic                                       m_arready,
    output logic [C_ADDR_WIDTH-1:0]                    m_araddr,
    output logic [7:0]                                 m_arlen,
    input  logic                                       r_hs,
    input  logic                                       r_last,
    output logic [$clog2(C_MAX_OUTSTANDING+1)-1:0]     outstanding
);
    localparam int OW = $clog2(C_MAX_OUTSTANDING+1);
    localparam logic [C_ADDR_WIDTH-1:0] BURST_BYTES = C_ADDR_WIDTH'(C_BURST_LEN*C_DATA_WIDTH/8);
    localparam logic [7:0] FULL_LEN = 8'(C_BURST_LEN-1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                  state, state_nx;
    logic [C_XFER_WIDTH-1:0] req_beats, rcv_beats, rcv_nx;
    logic [C_XFER_WIDTH-1:0] bursts_left, bursts_nx, start_bursts, rem;
    logic [C_XFER_WIDTH:0]   beats_ext;
    logic [7:0]              tail_len, start_tail;
    logic [OW-1:0]           out_nx;
    logic                    accept, ar_hs, retire, done_nx, arvalid_nx;

    always_comb begin
        beats_ext    = {1'b0, ctrl_xfer_beats} + (C_XFER_WIDTH+1)'(C_BURST_LEN-1);
        start_bursts = C_XFER_WIDTH'(beats_ext / (C_XFER_WIDTH+1)'(C_BURST_LEN));
        rem          = ctrl_xfer_beats % C_XFER_WIDTH'(C_BURST_LEN);
        start_tail   = (rem == '0) ? FULL_LEN : 8'(rem - C_XFER_WIDTH'(1));
        accept       = (state == IDLE) && ctrl_start;
        ar_hs        = m_arvalid && m_arready;
        // a retire with nothing in flight is a protocol error and is dropped
        retire       = r_hs && r_last && (outstanding != '0);
        out_nx       = outstanding + OW'(ar_hs) - OW'(retire);
        rcv_nx       = rcv_beats + C_XFER_WIDTH'(r_hs);
        bursts_nx    = bursts_left - C_XFER_WIDTH'(ar_hs);
        done_nx      = (state == DRAIN) && (out_nx == '0) && (rcv_nx == req_beats);
        state_nx     = accept ? ((ctrl_xfer_beats == '0) ? DRAIN : ISSUE) :
                       (state == ISSUE && ar_hs && bursts_left == C_XFER_WIDTH'(1)) ? DRAIN :
                       done_nx ? IDLE : state;
        // hold while stalled; otherwise present the next burst if the window has room
        arvalid_nx   = (state == ISSUE) && ((m_arvalid && !m_arready) ||
                       (bursts_nx != '0 && out_nx < OW'(C_MAX_OUTSTANDING)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            m_arvalid   <= 1'b0;
            m_araddr    <= '0;
            m_arlen     <= '0;
            outstanding <= '0;
            ctrl_busy   <= 1'b0;
            ctrl_done   <= 1'b0;
            req_beats   <= '0;
            rcv_beats   <= '0;
            bursts_left <= '0;
            tail_len    <= '0;
        end else begin
            state       <= state_nx;
            m_arvalid   <= arvalid_nx;
            outstanding <= out_nx;
            ctrl_done   <= done_nx;
            ctrl_busy   <= accept ? 1'b1 : done_nx ? 1'b0 : ctrl_busy;
            rcv_beats   <= accept ? '0 : rcv_nx;
            if (accept) begin
                req_beats   <= ctrl_xfer_beats;
                bursts_left <= start_bursts;
                tail_len    <= start_tail;
                m_araddr    <= ctrl_addr_offset;
                m_arlen     <= (start_bursts == C_XFER_WIDTH'(1)) ? start_tail : FULL_LEN;
            end else if (ar_hs) begin
                bursts_left <= bursts_nx;
                m_araddr    <= m_araddr + BURST_BYTES;
                m_arlen     <= (bursts_left == C_XFER_WIDTH'(2)) ? tail_len : FULL_LEN;
            end
        end
    end
endmodule

// File: tb/tb_axi_read_burst_tracker.sv
// tb_axi_read_burst_tracker: randomized and directed stimulus checked every cycle against
// a transaction-level model (expected burst list, in-flight count, beat count).
module tb_axi_read_burst_tracker;
    localparam int AW = 32, DW = 512, XW = 32, BL = 64, MO = 2;
    localparam int OW = $clog2(MO+1);
    localparam int BB = BL*DW/8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } burst_t;

    logic          clk = 1'b0, rst = 1'b1;
    logic          ctrl_start = 1'b0;
    logic [AW-1:0] ctrl_addr_offset = '0;
    logic [XW-1:0] ctrl_xfer_beats = '0;
    logic          ctrl_busy, ctrl_done, m_arvalid, m_arready = 1'b0;
    logic [AW-1:0] m_araddr;
    logic [7:0]    m_arlen;
    logic          r_hs = 1'b0, r_last = 1'b0;
    logic [OW-1:0] outstanding;

    axi_read_burst_tracker #(
        .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_XFER_WIDTH(XW),
        .C_BURST_LEN(BL), .C_MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst), .ctrl_start(ctrl_start), .ctrl_addr_offset(ctrl_addr_offset),
        .ctrl_xfer_beats(ctrl_xfer_beats), .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .r_hs(r_hs), .r_last(r_last), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    bit chk_en = 0;

    // model: phase 0 idle, 1 issuing, 2 draining
    burst_t  exp_q[$];
    int      rsp_q[$];
    int      rsp_cnt = 0;
    int      m_phase = 0, m_out = 0;
    bit      m_fresh = 0, m_busy = 0, m_done = 0;
    longint  m_rcv = 0, m_req = 0;

    int ar_pct = 100, r_pct = 100;
    bit rsp_en = 1, inj_ret = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit hs, ret, d;
        longint beats;
        burst_t b;
        if (rst) begin
            m_phase = 0; m_out = 0; m_fresh = 0; m_busy = 0; m_done = 0;
            m_rcv = 0; m_req = 0; rsp_cnt = 0;
            exp_q.delete(); rsp_q.delete();
        end else begin
            hs  = (m_arvalid === 1'b1) && m_arready;
            ret = r_hs && r_last && (m_out > 0);
            if (hs && exp_q.size() > 0) begin
                rsp_q.push_back(int'(exp_q[0].len));
                exp_q.pop_front();
            end
            m_out = m_out + int'(hs) - int'(ret);
            m_rcv = m_rcv + longint'(r_hs);
            d = (m_phase == 2) && (m_out == 0) && (m_rcv == m_req);
            m_fresh = 0;
            if (m_phase == 0 && ctrl_start) begin
                beats = longint'(ctrl_xfer_beats);
                for (longint i = 0; i * BL < beats; i++) begin
                    b.addr = AW'(longint'(ctrl_addr_offset) + i * BB);
                    b.len  = 8'((beats - i * BL >= BL) ? BL - 1 : beats - i * BL - 1);
                    exp_q.push_back(b);
                end
                m_req = beats; m_rcv = 0; m_busy = 1; m_fresh = 1;
                m_phase = (beats == 0) ? 2 : 1;
            end else if (m_phase == 1 && exp_q.size() == 0) begin
                m_phase = 2;
            end else if (d) begin
                m_phase = 0; m_busy = 0;
            end
            m_done = d;
        end
    end

    initial forever @(negedge clk) begin
        bit ev;
        if (chk_en) begin
            ev = (m_phase == 1) && !m_fresh && (exp_q.size() > 0) && (m_out < MO);
            check("arvalid", m_arvalid, ev);
            check("outstanding", outstanding, m_out);
            check("busy", ctrl_busy, m_busy);
            check("done", ctrl_done, m_done);
            if (ev) begin
                check("araddr", m_araddr, exp_q[0].addr);
                check("arlen", m_arlen, exp_q[0].len);
            end
        end
    end

    // AR ready and R responder; R beats only for bursts the DUT has handed over
    initial forever @(negedge clk) begin
        m_arready = (ar_pct >= 100) || ($urandom_range(99) < ar_pct);
        r_hs = 0; r_last = 0;
        if (inj_ret) begin
            r_hs = 1; r_last = 1;
        end else if (rsp_en && rsp_q.size() > 0 && $urandom_range(99) < r_pct) begin
            r_hs = 1;
            r_last = (rsp_cnt == rsp_q[0]);
            if (r_last) begin
                void'(rsp_q.pop_front());
                rsp_cnt = 0;
            end else rsp_cnt++;
        end
    end

    task automatic do_start(input logic [AW-1:0] a, input logic [XW-1:0] n);
        @(negedge clk);
        ctrl_start = 1; ctrl_addr_offset = a; ctrl_xfer_beats = n;
        @(negedge clk);
        ctrl_start = 0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (m_phase != 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (m_phase != 0) begin
            failures++;
            $display("FAIL timeout: transfer active after %0d cycles, required idle", lim);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 0;
        check("rst_arvalid", m_arvalid, 0);
        check("rst_araddr", m_araddr, 0);
        check("rst_arlen", m_arlen, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_busy", ctrl_busy, 0);
        check("rst_done", ctrl_done, 0);
        chk_en = 1;

        // zero-beat request: done two cycles after start, no AR
        do_start(32'h5000, 0);
        check("zero_c1_done", ctrl_done, 0);
        check("zero_c1_busy", ctrl_busy, 1);
        @(negedge clk);
        check("zero_c2_done", ctrl_done, 1);
        check("zero_c2_arvalid", m_arvalid, 0);
        @(negedge clk);
        check("zero_c3_done", ctrl_done, 0);

        // single burst
        do_start(32'h1000, 64);
        check("single_c1_arvalid", m_arvalid, 0);
        @(negedge clk);
        check("single_arvalid", m_arvalid, 1);
        check("single_araddr", m_araddr, 32'h1000);
        check("single_arlen", m_arlen, 63);
        wait_idle(500);
        check("single_out_end", outstanding, 0);

        // split with tail, stall hold, then outstanding limit
        ar_pct = 0; rsp_en = 0;
        do_start(32'h0, 150);
        @(negedge clk);
        check("split_model_n", exp_q.size(), 3);
        check("split_model_tail_addr", exp_q[2].addr, 32'h2000);
        check("split_model_tail_len", exp_q[2].len, 21);
        check("split_arvalid", m_arvalid, 1);
        check("split_araddr", m_araddr, 32'h0);
        check("split_arlen", m_arlen, 63);
        repeat (5) @(negedge clk);
        check("stall_araddr", m_araddr, 32'h0);
        ar_pct = 100;
        repeat (6) @(negedge clk);
        check("limit_out", outstanding, 2);
        check("limit_arvalid", m_arvalid, 0);
        check("limit_model_left", exp_q.size(), 1);
        rsp_en = 1;
        wait_idle(2000);

        // stray retire while idle must not wrap the count
        @(negedge clk); inj_ret = 1;
        @(negedge clk); inj_ret = 0;
        @(negedge clk);
        check("stray_retire_out", outstanding, 0);

        // reset mid-drain
        rsp_en = 0;
        do_start(32'h3000, 64);
        repeat (4) @(negedge clk);
        check("drain_out", outstanding, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("rstm_arvalid", m_arvalid, 0);
        check("rstm_araddr", m_araddr, 0);
        check("rstm_arlen", m_arlen, 0);
        check("rstm_outstanding", outstanding, 0);
        check("rstm_busy", ctrl_busy, 0);
        check("rstm_done", ctrl_done, 0);
        rsp_en = 1;

        // randomized transfers
        for (int t = 0; t < 30; t++) begin
            int sel;
            logic [XW-1:0] n;
            logic [AW-1:0] a;
            sel = $urandom_range(9);
            n = (sel == 0) ? 0 : (sel == 1) ? XW'(BL * $urandom_range(1, 3)) : XW'($urandom_range(1, 200));
            a = (sel == 2) ? 32'hFFFF_F000 : ($urandom & 32'hFFFF_F000);
            ar_pct = $urandom_range(30, 100);
            r_pct  = $urandom_range(50, 100);
            do_start(a, n);
            if (n != 0 && $urandom_range(1) == 1) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                do_start($urandom & 32'hFFFF_F000, XW'($urandom_range(1, 100)));
            end
            if (n != 0 && $urandom_range(7) == 0) begin
                repeat ($urandom_range(1, 20)) @(negedge clk);
                rst = 1;
                @(negedge clk);
                rst = 0;
            end
            wait_idle(5000);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_read_burst_tracker.md
# axi_read_burst_tracker

Read-side transaction engine for the kernel's AXI4 master port. It takes a transfer request in beats and splits it into aligned AR bursts, issuing them with a bounded number outstanding. It watches R-channel handshakes to retire bursts and pulses done once every requested beat has returned. It pairs with the up/down counter helper: the helper counts, and this block issues and retires the transactions being counted.

## Interface
Parameters:
- C_ADDR_WIDTH, 64, AXI address width.
- C_DATA_WIDTH, 512, AXI data width in bits; bytes per beat = C_DATA_WIDTH/8.
- C_XFER_WIDTH, 32, width of the beat-count request.
- C_BURST_LEN, 64, maximum beats per burst (1..256). C_BURST_LEN*C_DATA_WIDTH/8 must be ≤ 4096.
- C_MAX_OUTSTANDING, 16, maximum AR bursts accepted but not yet retired (≥1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ctrl_start  in  1  one-cycle request strobe, sampled only in IDLE.
- ctrl_addr_offset  in  C_ADDR_WIDTH  start byte address, aligned to C_BURST_LEN*C_DATA_WIDTH/8.
- ctrl_xfer_beats  in  C_XFER_WIDTH  total beats; 0 is legal.
- ctrl_busy  out  1  high from the cycle after an accepted start until done.
- ctrl_done  out  1  one-cycle completion pulse.
- m_arvalid  out  1  AR valid.
- m_arready  in  1  AR ready.
- m_araddr  out  C_ADDR_WIDTH  burst byte address.
- m_arlen  out  8  beats minus one.
- r_hs  in  1  an R beat was transferred this cycle (rvalid & rready at the port).
- r_last  in  1  RLAST qualifier for r_hs.
- outstanding  out  $clog2(C_MAX_OUTSTANDING+1)  bursts issued and not yet retired.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - On ctrl_start, latch addr and beats. Burst count = ceil(beats/C_BURST_LEN). Final burst length = beats mod C_BURST_LEN, or C_BURST_LEN when the remainder is 0.
  - If beats == 0, go to DRAIN with nothing to issue. Otherwise go to ISSUE.
- ISSUE:
  - m_arvalid rises only when outstanding < C_MAX_OUTSTANDING.
  - Once m_arvalid is high, it and m_araddr/m_arlen hold stable until the handshake, per AXI.
  - On each AR handshake:
    - outstanding increments.
    - m_araddr advances by C_BURST_LEN*C_DATA_WIDTH/8.
    - The remaining-burst count decrements.
    - m_arlen = C_BURST_LEN-1, except the final burst.
  - After the last AR handshake, go to DRAIN.
- Retire: r_hs & r_last decrements outstanding.
  - A retire in the same cycle as an AR handshake leaves outstanding unchanged.
  - A retire at outstanding == 0 is a protocol error. Ignore it; the count must not wrap.
- Beat counting: each r_hs increments a C_XFER_WIDTH received-beat counter, which is cleared on accepted start.
- DRAIN: when outstanding == 0 and received == requested beats, pulse ctrl_done and return to IDLE.
- Back-pressure: ctrl_start while not in IDLE is ignored and does not disturb the transfer.
- Address arithmetic wraps modulo 2^C_ADDR_WIDTH. No 4 KB check is needed; the alignment rule guarantees no crossing.

## Timing
- Reset values: state IDLE; m_arvalid 0; m_araddr 0; m_arlen 0; outstanding 0; ctrl_busy 0; ctrl_done 0; internal counters 0.
- A reset asserted mid-transfer returns all of the above to reset values on the next edge. Nothing is preserved.
- start → m_arvalid: start sampled at edge N; ctrl_busy and m_arvalid high after edge N+1.
- Back-to-back bursts: with m_arready held high and outstanding below the limit, one AR issues per cycle with no bubbles.
- outstanding reflects handshakes one cycle after the edge on which they occur (registered).
- Done:
  - ctrl_done asserts the cycle after the retiring r_hs & r_last that satisfies both completion conditions.
  - ctrl_busy falls in that same cycle.
  - A new start is accepted on the cycle after done.
- Zero-beat request: ctrl_done pulses exactly 2 cycles after start, with no AR issued.

## Test plan
- Single burst: start with addr 0x1000, beats 64 → one AR (araddr 0x1000, arlen 63). Feed 64 beats with last on beat 64 → done pulses once; outstanding returns to 0.
- Split with partial tail: beats 150, C_BURST_LEN 64 → ARs at 0x0/0x1000/0x2000 with arlen 63/63/21. Done fires only after beat 150.
- Outstanding limit: C_MAX_OUTSTANDING 2, beats 256, no R traffic → exactly 2 ARs and arvalid stays low. One retire → third AR issues on the following cycles.
- Stall hold: m_arready low for 5 cycles during ISSUE → arvalid, araddr and arlen unchanged every cycle until the handshake.
- Simultaneous events: AR handshake and r_hs & r_last in the same cycle → outstanding unchanged. Extra ctrl_start mid-transfer → ignored.
- Reset and zero: rst asserted mid-DRAIN → all outputs at reset values next cycle. Start with beats 0 → done 2 cycles later, with no AR issued.
